e203_csr_port_arbiter: RTL and testbench

E203_CSR_PORT_ARBITER -- requirements
Module: e203_csr_port_arbiter

---
 rtl/e203_csr_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_e203_csr_port_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_csr_port_arbiter.sv
// ---------------------------------------------------------------------------
// e203_csr_port_arbiter
//
// Shares one CSR file port between two requesters: the core (CSR
// instructions) and the debug module (abstract commands). Each accepted
// request runs IDLE -> ACCESS -> RESP -> IDLE, so one access completes at
// most every three cycles.
//
// Handshake semantics (all valid/ready pairs): a transfer happens in a cycle
// where valid and ready are both high at the rising clock edge. A requester
// holds valid and payload stable until it sees ready. A response is held
// stable with rsp_valid high until the owner's rsp_ready is high.
//
// Configuration macro: E203_CSR_ARB_RR_EN
//   defined   - round-robin between the two requesters (1-bit last-grant flop)
//   undefined - fixed priority, debug always wins a tie
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   core_req_* / dbg_req_*        request channel (valid/ready, wr, rd, idx, wdat)
//   core_rsp_* / dbg_rsp_*        response channel (valid/ready, rdat, err)
//   csr_ena, csr_wr_en, csr_rd_en CSR file strobes, high only in ACCESS
//   csr_idx, wbck_csr_dat         CSR index / write data, zero outside ACCESS
//   read_csr_dat, csr_access_ilgl CSR file read data / illegal flag (ACCESS)
//   arb_state_o                   current FSM state for observation
// ---------------------------------------------------------------------------
module e203_csr_port_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            core_req_valid,
  output logic            core_req_ready,
  input  logic            core_req_wr,
  input  logic            core_req_rd,
  input  logic [11:0]     core_req_idx,
  input  logic [XLEN-1:0] core_req_wdat,
  output logic            core_rsp_valid,
  input  logic            core_rsp_ready,
  output logic [XLEN-1:0] core_rsp_rdat,
  output logic            core_rsp_err,
  input  logic            dbg_req_valid,
  output logic            dbg_req_ready,
  input  logic            dbg_req_wr,
  input  logic            dbg_req_rd,
  input  logic [11:0]     dbg_req_idx,
  input  logic [XLEN-1:0] dbg_req_wdat,
  output logic            dbg_rsp_valid,
  input  logic            dbg_rsp_ready,
  output logic [XLEN-1:0] dbg_rsp_rdat,
  output logic            dbg_rsp_err,
  output logic            csr_ena,
  output logic            csr_wr_en,
  output logic            csr_rd_en,
  output logic [11:0]     csr_idx,
  output logic [XLEN-1:0] wbck_csr_dat,
  input  logic [XLEN-1:0] read_csr_dat,
  input  logic            csr_access_ilgl,
  output logic [1:0]      arb_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e          state_q;
  logic            owner_q;   // 1: debug owns the in-flight access, 0: core
  logic            wr_q;
  logic            rd_q;
  logic [11:0]     idx_q;
  logic [XLEN-1:0] wdat_q;
  logic [XLEN-1:0] rdat_q;
  logic            err_q;

  logic grant_dbg;
  logic grant_core;
  logic owner_rsp_ready;
  logic in_access;
  logic in_resp;

`ifdef E203_CSR_ARB_RR_EN
  logic last_dbg_q;           // 1: the most recent grant went to debug
`endif

  // Grant decision; only in IDLE, and suppressed while reset is asserted so
  // every output reads 0 during reset.
  always_comb begin
    grant_dbg  = 1'b0;
    grant_core = 1'b0;
    if (state_q == ST_IDLE && !rst) begin
      if (dbg_req_valid && core_req_valid) begin
`ifdef E203_CSR_ARB_RR_EN
        grant_dbg = !last_dbg_q;
`else
        grant_dbg = 1'b1;
`endif
        grant_core = !grant_dbg;
      end else begin
        grant_dbg  = dbg_req_valid;
        grant_core = core_req_valid;
      end
    end
  end

  assign owner_rsp_ready = owner_q ? dbg_rsp_ready : core_rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      idx_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
`ifdef E203_CSR_ARB_RR_EN
      // "Last grant was core" so the first tie after reset goes to debug.
      last_dbg_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (grant_dbg || grant_core) begin
            owner_q <= grant_dbg;
            wr_q    <= grant_dbg ? dbg_req_wr   : core_req_wr;
            rd_q    <= grant_dbg ? dbg_req_rd   : core_req_rd;
            idx_q   <= grant_dbg ? dbg_req_idx  : core_req_idx;
            wdat_q  <= grant_dbg ? dbg_req_wdat : core_req_wdat;
            state_q <= ST_ACCESS;
`ifdef E203_CSR_ARB_RR_EN
            last_dbg_q <= grant_dbg;
`endif
          end
        end
        ST_ACCESS: begin
          // Illegal accesses and non-reads never return CSR data.
          rdat_q  <= (csr_access_ilgl || !rd_q) ? '0 : read_csr_dat;
          err_q   <= csr_access_ilgl;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (owner_rsp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_access = (state_q == ST_ACCESS);
  assign in_resp   = (state_q == ST_RESP);

  assign core_req_ready = grant_core;
  assign dbg_req_ready  = grant_dbg;

  assign csr_ena      = in_access;
  assign csr_wr_en    = in_access & wr_q;
  assign csr_rd_en    = in_access & rd_q;
  assign csr_idx      = in_access ? idx_q  : '0;
  assign wbck_csr_dat = in_access ? wdat_q : '0;

  assign core_rsp_valid = in_resp & !owner_q;
  assign core_rsp_rdat  = core_rsp_valid ? rdat_q : '0;
  assign core_rsp_err   = core_rsp_valid & err_q;
  assign dbg_rsp_valid  = in_resp & owner_q;
  assign dbg_rsp_rdat   = dbg_rsp_valid ? rdat_q : '0;
  assign dbg_rsp_err    = dbg_rsp_valid & err_q;

  assign arb_state_o = state_q;

endmodule

// File: tb/tb_e203_csr_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_e203_csr_port_arbiter
//
// Requester tasks issue CSR requests; on acceptance they push the expected
// CSR access and expected response (computed from a small CSR-file model)
// into queues. A monitor on the falling edge predicts grants from the
// arbitration rule, enforces the accept/access/response timing, and pops the
// queues as the DUT presents accesses and responses.
// ---------------------------------------------------------------------------
module tb_e203_csr_port_arbiter;
  localparam int XLEN  = 32;
  localparam int ACC_W = 3 + 12 + XLEN;   // {ena, wr, rd, idx, wdat}
  localparam int RSP_W = 2 + XLEN;        // {owner_is_dbg, err, rdat}
`ifdef E203_CSR_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            core_req_valid, core_req_ready, core_req_wr, core_req_rd;
  logic [11:0]     core_req_idx;
  logic [XLEN-1:0] core_req_wdat;
  logic            core_rsp_valid, core_rsp_ready, core_rsp_err;
  logic [XLEN-1:0] core_rsp_rdat;
  logic            dbg_req_valid, dbg_req_ready, dbg_req_wr, dbg_req_rd;
  logic [11:0]     dbg_req_idx;
  logic [XLEN-1:0] dbg_req_wdat;
  logic            dbg_rsp_valid, dbg_rsp_ready, dbg_rsp_err;
  logic [XLEN-1:0] dbg_rsp_rdat;
  logic            csr_ena, csr_wr_en, csr_rd_en;
  logic [11:0]     csr_idx;
  logic [XLEN-1:0] wbck_csr_dat;
  logic [XLEN-1:0] read_csr_dat;
  logic            csr_access_ilgl;
  logic [1:0]      arb_state;

  e203_csr_port_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_wr(core_req_wr), .core_req_rd(core_req_rd),
    .core_req_idx(core_req_idx), .core_req_wdat(core_req_wdat),
    .core_rsp_valid(core_rsp_valid), .core_rsp_ready(core_rsp_ready),
    .core_rsp_rdat(core_rsp_rdat), .core_rsp_err(core_rsp_err),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_req_wr(dbg_req_wr), .dbg_req_rd(dbg_req_rd),
    .dbg_req_idx(dbg_req_idx), .dbg_req_wdat(dbg_req_wdat),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
    .dbg_rsp_rdat(dbg_rsp_rdat), .dbg_rsp_err(dbg_rsp_err),
    .csr_ena(csr_ena), .csr_wr_en(csr_wr_en), .csr_rd_en(csr_rd_en),
    .csr_idx(csr_idx), .wbck_csr_dat(wbck_csr_dat),
    .read_csr_dat(read_csr_dat), .csr_access_ilgl(csr_access_ilgl),
    .arb_state_o(arb_state)
  );

  // CSR file model: fixed contents, indices ending in 0xF are illegal.
  function automatic logic [XLEN-1:0] csr_file(input logic [11:0] idx);
    if (idx == 12'h7B1) return 32'h8000_0104;
    return {idx, ~idx, 8'h5A};
  endfunction

  function automatic logic is_ilgl(input logic [11:0] idx);
    return idx[3:0] == 4'hF;
  endfunction

  // Arbitration rule: sole requester wins; on a tie debug wins unless
  // round-robin is on and debug was granted last.
  function automatic bit pick_dbg(input bit cv, input bit dv, input bit last_dbg);
    if (!cv) return 1'b1;
    if (!dv) return 1'b0;
    return RR_EN ? !last_dbg : 1'b1;
  endfunction

  assign read_csr_dat    = csr_file(csr_idx);
  assign csr_access_ilgl = is_ilgl(csr_idx);

  logic [ACC_W-1:0] acc_q[$];
  logic [RSP_W-1:0] rsp_q[$];
  bit               grant_log[$];
  int               checks = 0;
  int               errors = 0;
  bit               mon_busy;
  int               rdy_mode;   // 0: hold low, 1: always high, 2: random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur (t=%0t)", name, $time);
  endtask

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- response ready driver ----------------
  initial begin
    core_rsp_ready = 1'b0;
    dbg_rsp_ready  = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: begin core_rsp_ready = 1'b0; dbg_rsp_ready = 1'b0; end
        1: begin core_rsp_ready = 1'b1; dbg_rsp_ready = 1'b1; end
        default: begin
          core_rsp_ready = 1'($urandom_range(0, 1));
          dbg_rsp_ready  = 1'($urandom_range(0, 1));
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input bit is_dbg, input bit v, input bit wr, input bit rd,
                         input logic [11:0] idx, input logic [XLEN-1:0] wdat);
    if (is_dbg) begin
      dbg_req_valid = v; dbg_req_wr = wr; dbg_req_rd = rd;
      dbg_req_idx = idx; dbg_req_wdat = wdat;
    end else begin
      core_req_valid = v; core_req_wr = wr; core_req_rd = rd;
      core_req_idx = idx; core_req_wdat = wdat;
    end
  endtask

  // Present one request, hold it until accepted, push expectations, drop valid.
  task automatic do_req(input bit is_dbg, input bit wr, input bit rd,
                        input logic [11:0] idx, input logic [XLEN-1:0] wdat);
    bit              got;
    logic            err;
    logic [XLEN-1:0] rdat;
    got = 1'b0;
    @(posedge clk); #1;
    set_req(is_dbg, 1'b1, wr, rd, idx, wdat);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (is_dbg ? dbg_req_ready : core_req_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      err  = is_ilgl(idx);
      rdat = (err || !rd) ? '0 : csr_file(idx);
      acc_q.push_back({1'b1, wr, rd, idx, wdat});
      rsp_q.push_back({is_dbg, err, rdat});
    end else begin
      fail(is_dbg ? "dbg_req_grant" : "core_req_grant");
    end
    @(posedge clk); #1;
    set_req(is_dbg, 1'b0, 1'b0, 1'b0, 12'h0, '0);
  endtask

  task automatic req_task(input bit is_dbg, input int n, input bit b2b);
    for (int i = 0; i < n; i++) begin
      if (!b2b) repeat ($urandom_range(0, 3)) @(posedge clk);
      do_req(is_dbg, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             12'($urandom_range(0, 4095)), $urandom);
    end
  endtask

  task automatic wait_drain(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (!mon_busy && acc_q.size() == 0 && rsp_q.size() == 0 &&
          !core_req_valid && !dbg_req_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail({tag, "_drain"});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 64'({core_req_ready, dbg_req_ready, core_rsp_valid, dbg_rsp_valid,
                               core_rsp_err, dbg_rsp_err, csr_ena, csr_wr_en, csr_rd_en,
                               csr_idx}), 64'h0);
    check({tag, "_core_rdat"}, 64'(core_rsp_rdat), 64'h0);
    check({tag, "_dbg_rdat"}, 64'(dbg_rsp_rdat), 64'h0);
    check({tag, "_wbck"}, 64'(wbck_csr_dat), 64'h0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int               age;
    bit               last_dbg;
    bit               w;
    bit               exp_grant;
    logic [ACC_W-1:0] ea;
    logic [RSP_W-1:0] er;
    logic [XLEN+1:0]  exp_core;
    logic [XLEN+1:0]  exp_dbg;
    mon_busy = 1'b0;
    age      = 0;
    last_dbg = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_busy = 1'b0;
        age      = 0;
        last_dbg = 1'b0;
        acc_q.delete();
        rsp_q.delete();
      end else begin
        if (mon_busy) age++;
        exp_grant = !mon_busy && (core_req_valid || dbg_req_valid);
        w = pick_dbg(core_req_valid, dbg_req_valid, last_dbg);
        check("req_ready", 64'({core_req_ready, dbg_req_ready}),
              64'(exp_grant ? {!w, w} : 2'b00));
        if (core_req_ready || dbg_req_ready) grant_log.push_back(dbg_req_ready);

        if (mon_busy && age == 1) begin
          if (acc_q.size() == 0) begin
            fail("csr_access_expectation");
            ea = '0;
          end else begin
            ea = acc_q.pop_front();
          end
          check("csr_access", 64'({csr_ena, csr_wr_en, csr_rd_en, csr_idx, wbck_csr_dat}), 64'(ea));
        end else begin
          check("csr_quiet", 64'({csr_ena, csr_wr_en, csr_rd_en, csr_idx, wbck_csr_dat}), 64'h0);
        end

        if (mon_busy && age >= 2) begin
          if (rsp_q.size() == 0) begin
            fail("rsp_expectation");
            er = '0;
          end else begin
            er = rsp_q[0];
          end
          exp_core = er[XLEN+1] ? '0 : {1'b1, er[XLEN:0]};
          exp_dbg  = er[XLEN+1] ? {1'b1, er[XLEN:0]} : '0;
          check("core_rsp", 64'({core_rsp_valid, core_rsp_err, core_rsp_rdat}), 64'(exp_core));
          check("dbg_rsp", 64'({dbg_rsp_valid, dbg_rsp_err, dbg_rsp_rdat}), 64'(exp_dbg));
          if (er[XLEN+1] ? dbg_rsp_ready : core_rsp_ready) begin
            if (rsp_q.size() != 0) void'(rsp_q.pop_front());
            mon_busy = 1'b0;
          end else if (age > 200) begin
            fail("rsp_handshake");
            mon_busy = 1'b0;
          end
        end else begin
          check("core_rsp_quiet", 64'({core_rsp_valid, core_rsp_err, core_rsp_rdat}), 64'h0);
          check("dbg_rsp_quiet", 64'({dbg_rsp_valid, dbg_rsp_err, dbg_rsp_rdat}), 64'h0);
        end

        if (exp_grant) begin
          mon_busy = 1'b1;
          age      = 0;
          last_dbg = w;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    rdy_mode = 1;
    rst      = 1'b1;
    set_req(1'b0, 1'b1, 1'b1, 1'b1, 12'h340, 32'h1234_5678);
    set_req(1'b1, 1'b1, 1'b0, 1'b1, 12'h7B1, 32'h0);

    // Outputs stay 0 in reset even with both requesters valid.
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    check("reset_state", 64'(arb_state), 64'h0);
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 12'h0, '0);
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, '0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Core write, debug read, no-op request.
    do_req(1'b0, 1'b1, 1'b0, 12'h340, 32'hDEAD_BEEF);
    wait_drain("core_write");
    do_req(1'b1, 1'b0, 1'b1, 12'h7B1, $urandom);
    wait_drain("dbg_read");
    do_req(1'b0, 1'b0, 1'b0, 12'h300, $urandom);
    wait_drain("noop");

    // Illegal core read with the response held off for 5 cycles.
    rdy_mode = 0;
    do_req(1'b0, 1'b0, 1'b1, 12'h34F, $urandom);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (core_rsp_valid) begin seen = 1'b1; break; end
    end
    if (!seen) fail("ilgl_rsp_valid");
    repeat (5) @(negedge clk);
    rdy_mode = 1;
    wait_drain("ilgl_hold");

    // Both requesters continuously valid.
    grant_log.delete();
    fork
      req_task(1'b1, 4, 1'b1);
      req_task(1'b0, 4, 1'b1);
    join
    wait_drain("tie");
    for (int i = 0; i < 4; i++) begin
      if (grant_log.size() <= i) fail($sformatf("grant_order_%0d", i));
      else check($sformatf("grant_order_%0d", i), 64'(grant_log[i]),
                 64'(RR_EN ? (i % 2 == 0) : 1'b1));
    end

    // Randomized traffic with random response backpressure.
    rdy_mode = 2;
    fork
      req_task(1'b0, 25, 1'b0);
      req_task(1'b1, 25, 1'b0);
    join
    rdy_mode = 1;
    wait_drain("random");

    // Reset while a debug response is pending.
    rdy_mode = 0;
    do_req(1'b1, 1'b0, 1'b1, 12'h7B1, $urandom);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dbg_rsp_valid) begin seen = 1'b1; break; end
    end
    if (!seen) fail("rst_test_rsp_valid");
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_dbg_rsp_valid", 64'(dbg_rsp_valid), 64'h0);
    check_all_zero("mid_rsp_reset");
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    check("post_reset_state", 64'(arb_state), 64'h0);
    rdy_mode = 1;
    grant_log.delete();
    fork
      do_req(1'b0, 1'b1, 1'b1, 12'h305, $urandom);
      do_req(1'b1, 1'b1, 1'b1, 12'h7B0, $urandom);
    join
    wait_drain("post_reset");
    if (grant_log.size() == 0) fail("post_reset_tie");
    else check("post_reset_tie", 64'(grant_log[0]), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
